clk_div_bank: RTL and testbench

Parametrised clock-enable divider bank for the Astra telemetry core. From one master clock it generates CHANNELS phase-aligned divided clocks and single-cycle strobes. Ratios for the 640 kHz, 320 kHz and 8 kHz timebases are set per channel. It also includes a built-in power-up hold that raises `ready` only after the start-up delay. Frame formatters, DAC drivers and the UART bit timer use its strobes; they may re-phase all channels together with `sync_req`.

---
 rtl/clk_div_bank.sv | 139 +++++++++++++
 tb/tb_clk_div_bank.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// Clock-enable divider bank: power-up hold, phase-aligned divided clocks and strobes, sync restart.
// Optional runtime ratio loading is enabled by defining DIVBANK_RATIO_LOAD_EN.
module clk_div_bank #(
   parameter int                          CHANNELS    = 3,
   parameter int                          CNT_W       = 16,
   parameter logic [CHANNELS*CNT_W-1:0]   DIVS        = {16'd10080, 16'd252, 16'd126},
   parameter int                          HOLD_CYCLES = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sync_req,
   output logic                ready,
   output logic [CHANNELS-1:0] clk_out,
   output logic [CHANNELS-1:0] stb
`ifdef DIVBANK_RATIO_LOAD_EN
   ,
   input  logic                ld_en,
   input  logic [2:0]          ld_ch,
   input  logic [CNT_W-1:0]    ld_div,
   output logic                ld_ack,
   output logic                ld_err
`endif
);

   localparam int HOLD_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES);

   logic [HOLD_W-1:0] r_hold;
   logic              r_ready;
   logic              r_sync_q;
   logic              w_start;
   logic              w_restart;

   // w_start marks the edge on which ready rises; every channel begins at t=0 there
   assign w_start   = !r_ready && (r_hold == HOLD_W'(HOLD_CYCLES - 1));
   assign w_restart = w_start || (r_ready && sync_req && !r_sync_q);
   assign ready     = r_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hold   <= '0;
         r_ready  <= 1'b0;
         r_sync_q <= 1'b0;
      end else begin
         r_sync_q <= sync_req;
         if (!r_ready) begin
            r_hold <= r_hold + 1'b1;
            if (w_start) r_ready <= 1'b1;
         end
      end
   end

`ifdef DIVBANK_RATIO_LOAD_EN
   logic r_ld_ack;
   logic r_ld_err;
   logic w_ld_ok;

   assign w_ld_ok = ld_en && r_ready && (int'(ld_ch) < CHANNELS) && (ld_div >= CNT_W'(2));
   assign ld_ack  = r_ld_ack;
   assign ld_err  = r_ld_err;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ld_ack <= 1'b0;
         r_ld_err <= 1'b0;
      end else begin
         r_ld_ack <= w_ld_ok;
         r_ld_err <= ld_en && !w_ld_ok;
      end
   end
`endif

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      localparam logic [CNT_W-1:0] P_RAW = DIVS[g*CNT_W +: CNT_W];
      localparam logic [CNT_W-1:0] P_DIV = (P_RAW < CNT_W'(2)) ? CNT_W'(2) : P_RAW;

      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] r_div;
      logic             r_stb;
      logic             r_clk;
      logic [CNT_W-1:0] w_div_nxt;
      logic [CNT_W-1:0] w_cnt_nxt;
      logic [CNT_W-1:0] w_half;
      logic             w_bound;

`ifdef DIVBANK_RATIO_LOAD_EN
      logic [CNT_W-1:0] r_pend;
      logic             r_pend_v;
      logic             w_ld_wr;

      assign w_ld_wr   = w_ld_ok && (ld_ch == 3'(g));
      assign w_div_nxt = r_pend_v ? r_pend : r_div;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_pend   <= P_DIV;
            r_pend_v <= 1'b0;
         end else if (w_ld_wr) begin
            r_pend   <= ld_div;
            r_pend_v <= 1'b1;
         end else if (w_bound) begin
            r_pend_v <= 1'b0;
         end
      end
`else
      assign w_div_nxt = r_div;
`endif

      // a period boundary is a natural wrap or a restart; both take the pending ratio
      assign w_bound   = w_restart || (r_ready && (r_cnt == r_div - 1'b1));
      assign w_cnt_nxt = r_cnt + 1'b1;
      assign w_half    = (r_div >> 1) + {{(CNT_W-1){1'b0}}, r_div[0]};

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_cnt <= '0;
            r_div <= P_DIV;
            r_stb <= 1'b0;
            r_clk <= 1'b0;
         end else if (w_bound) begin
            r_cnt <= '0;
            r_div <= w_div_nxt;
            r_stb <= 1'b1;
            r_clk <= 1'b1;
         end else if (r_ready) begin
            r_cnt <= w_cnt_nxt;
            r_stb <= 1'b0;
            r_clk <= (w_cnt_nxt < w_half);
         end else begin
            r_cnt <= '0;
            r_stb <= 1'b0;
            r_clk <= 1'b0;
         end
      end

      assign stb[g]     = r_stb;
      assign clk_out[g] = r_clk;
   end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: default bank plus a single D=5 channel sharing clock, reset and sync.
module tb_clk_div_bank;
   localparam int D0 = 126;
   localparam int D1 = 252;
   localparam int D2 = 10080;

   logic       clk = 1'b0;
   logic       reset;
   logic       sync_req;
   logic       ready, ready5;
   logic [2:0] clk_out, stb;
   logic [0:0] clk_out5, stb5;
   int         n_tests = 0;
   int         n_fail  = 0;
   int         t = 0;
   int         pat5 [5] = '{1, 1, 1, 0, 0};

   always #5 clk = ~clk;

`ifdef DIVBANK_RATIO_LOAD_EN
   logic        ld_en = 1'b0;
   logic [2:0]  ld_ch = 3'd0;
   logic [15:0] ld_div = 16'd0;
   logic        ld_ack, ld_err, ld_ack5, ld_err5;

   clk_div_bank u_dut (
      .clk(clk), .reset(reset), .sync_req(sync_req), .ready(ready), .clk_out(clk_out), .stb(stb),
      .ld_en(ld_en), .ld_ch(ld_ch), .ld_div(ld_div), .ld_ack(ld_ack), .ld_err(ld_err));
   clk_div_bank #(.CHANNELS(1), .CNT_W(16), .DIVS(16'd5), .HOLD_CYCLES(16)) u_dut5 (
      .clk(clk), .reset(reset), .sync_req(sync_req), .ready(ready5), .clk_out(clk_out5), .stb(stb5),
      .ld_en(ld_en), .ld_ch(ld_ch), .ld_div(ld_div), .ld_ack(ld_ack5), .ld_err(ld_err5));
`else
   clk_div_bank u_dut (
      .clk(clk), .reset(reset), .sync_req(sync_req), .ready(ready), .clk_out(clk_out), .stb(stb));
   clk_div_bank #(.CHANNELS(1), .CNT_W(16), .DIVS(16'd5), .HOLD_CYCLES(16)) u_dut5 (
      .clk(clk), .reset(reset), .sync_req(sync_req), .ready(ready5), .clk_out(clk_out5), .stb(stb5));
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // expected outputs follow directly from t mod D for each fixed ratio
   task automatic check_all();
      logic [2:0] es, ec;
      es[0] = (t % D0) == 0;  ec[0] = (t % D0) < (D0 + 1) / 2;
      es[1] = (t % D1) == 0;  ec[1] = (t % D1) < (D1 + 1) / 2;
      es[2] = (t % D2) == 0;  ec[2] = (t % D2) < (D2 + 1) / 2;
      chk("ready", 32'(ready), 32'd1);
      chk("stb", 32'(stb), 32'(es));
      chk("clk_out", 32'(clk_out), 32'(ec));
      chk("stb5", 32'(stb5), 32'((t % 5) == 0));
      chk("clk_out5", 32'(clk_out5), 32'(pat5[t % 5]));
   endtask

   task automatic run_check(input int n);
      for (int k = 0; k < n; k++) begin
         check_all();
         step();
         t++;
      end
   endtask

   task automatic release_and_hold();
      reset = 1'b0;
      repeat (15) step();
      chk("hold_early_ready", 32'(ready), 32'd0);
      chk("hold_early_stb", 32'(stb), 32'd0);
      step();
      chk("ready_rise", 32'(ready), 32'd1);
      chk("ready_stb_all", 32'(stb), 32'h7);
      chk("ready_clk_all", 32'(clk_out), 32'h7);
      t = 0;
   endtask

   initial begin
      reset    = 1'b1;
      sync_req = 1'b0;
      repeat (3) step();
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_stb", 32'(stb), 32'd0);
      chk("rst_clk_out", 32'(clk_out), 32'd0);
      chk("rst_ready5", 32'(ready5), 32'd0);
`ifdef DIVBANK_RATIO_LOAD_EN
      chk("rst_ld_ack", 32'(ld_ack), 32'd0);
      chk("rst_ld_err", 32'(ld_err), 32'd0);
`endif
      release_and_hold();
      run_check(40);

      // single sync pulse at t=40 restarts everything at the next cycle
      check_all();
      sync_req = 1'b1;
      step();
      sync_req = 1'b0;
      t = 0;
      chk("sync_stb_all", 32'(stb), 32'h7);
      run_check(10090);

      // sync held high for 500 cycles gives exactly one restart
      sync_req = 1'b1;
      step();
      t = 0;
      run_check(500);
      sync_req = 1'b0;
      run_check(300);

      // restart landing on the cycle a natural boundary would have fallen
      run_check(125 - (t % 126));
      check_all();
      sync_req = 1'b1;
      step();
      sync_req = 1'b0;
      t = 0;
      run_check(300);

      // asynchronous reset mid-period at t=300
      reset = 1'b1;
      #1;
      chk("async_rst_ready", 32'(ready), 32'd0);
      chk("async_rst_stb", 32'(stb), 32'd0);
      chk("async_rst_clk_out", 32'(clk_out), 32'd0);
      chk("async_rst_clk_out5", 32'(clk_out5), 32'd0);
      step();
      step();
      release_and_hold();
      run_check(130);

`ifdef DIVBANK_RATIO_LOAD_EN
      reset = 1'b1;
      step();
      release_and_hold();
      run_check(10);
      ld_en  = 1'b1;
      ld_ch  = 3'd1;
      ld_div = 16'd100;
      step();
      t = 11;
      for (int k = 0; k < 450; k++) begin
         chk("ld_ack", 32'(ld_ack), 32'(t == 11));
         chk("ld_err", 32'(ld_err), 32'(t == 21 || t == 31));
         chk("ld_stb1", 32'(stb[1]), 32'(t == 252 || t == 352 || t == 452));
         chk("ld_stb0", 32'(stb[0]), 32'((t % D0) == 0));
         ld_en  = (t == 20) || (t == 30);
         ld_ch  = (t == 20) ? 3'd5 : 3'd1;
         ld_div = (t == 30) ? 16'd1 : 16'd50;
         step();
         t++;
      end
      ld_en = 1'b0;

      // reset brings back the build-time ratios
      reset = 1'b1;
      step();
      release_and_hold();
      run_check(260);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
